// File: rtl/pattern_match_pkg.sv
// Shared types and default sizes for the programmable serial-pattern detector.
package pattern_match_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pm_state_t;

endpackage

// File: rtl/pattern_shift_cmp.sv
// Serial history shift register with fill tracking and a length-masked pattern compare.
module pattern_shift_cmp #(
  parameter  int PAT_W = 4,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam logic [LEN_W:0] ONE = (LEN_W + 1)'(1);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_d;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W:0]   fill_inc;
  logic [LEN_W:0]   len_ext;
  logic             full_after;
  logic [PAT_W-1:0] mask;

  assign hist_d     = {hist_q[PAT_W-2:0], bit_in};
  assign fill_inc   = {1'b0, fill_q} + ONE;
  assign len_ext    = {1'b0, len};
  assign full_after = (fill_inc >= len_ext);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // hit describes the history as it will be after this edge's shift
  assign hit = shift_en && full_after && (((hist_d ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_d;
      fill_q <= full_after ? len : fill_inc[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Programmable overlapping serial-pattern detector with config handshake, match counting and done/ack.
//  state | meaning
//  IDLE  | waiting for a config; last match_count held
//  RUN   | sampling A on a_valid, counting matches toward target
//  DONE  | target reached; count held until done_ack or abort
module pattern_match_ctrl
  import pattern_match_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             A,
  input  logic             a_valid,
  input  logic             abort,
  input  logic             done_ack,
  output logic             match,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pm_state_t        state_q;
  pm_state_t        state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic [LEN_W-1:0] len_clamped;
  logic             match_q;
  logic             accept;
  logic             shift_en;
  logic             hit;

  assign len_clamped = (cfg_len == '0)     ? LEN_MIN :
                       (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  assign count_inc = count_q + CNT_ONE;
  // abort takes priority over a same-cycle hit, so it also blocks the shift
  assign shift_en  = (state_q == RUN) && a_valid && !abort;

  pattern_shift_cmp #(
    .PAT_W (PAT_W)
  ) u_shift_cmp (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (A),
    .len      (len_q),
    .pattern  (pat_q),
    .hit      (hit)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = (cfg_target == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hit && (count_inc == target_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ack || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      match_q  <= 1'b0;
      count_q  <= '0;
      pat_q    <= '0;
      len_q    <= LEN_MIN;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= hit;
      if (accept) begin
        pat_q    <= cfg_pattern;
        len_q    <= len_clamped;
        target_q <= cfg_target;
        count_q  <= '0;
      end else if (hit) begin
        count_q <= count_inc;
      end
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign match       = match_q;
  assign match_count = count_q;

endmodule
